call_context_ctrl: RTL and testbench

CALL_CONTEXT_CTRL -- requirements
Module: call_context_ctrl

---
 rtl/ctx_pkg.sv | 48 ++++
 rtl/ctx_ram.sv | 25 ++
 rtl/call_context_ctrl.sv | 164 ++++++++++++++++
 tb/tb_call_context_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ctx_pkg.sv
// Shared constants for the call-context save/restore controller: register
// codes, frame word order, FSM encoding and the default frame depth.
package ctx_pkg;

  localparam int DEFAULT_DEPTH = 64;

  localparam logic [7:0] CODE_EAX = 8'h80;
  localparam logic [7:0] CODE_EBX = 8'hA0;
  localparam logic [7:0] CODE_ECX = 8'hC0;
  localparam logic [7:0] CODE_EDX = 8'hE0;

  localparam logic [1:0] WORD_EAX = 2'd0;
  localparam logic [1:0] WORD_EBX = 2'd1;
  localparam logic [1:0] WORD_ECX = 2'd2;
  localparam logic [1:0] WORD_EDX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } ctx_state_e;

  function automatic logic [7:0] reg_code(input logic [1:0] word);
    logic [7:0] code;
    case (word)
      WORD_EAX: code = CODE_EAX;
      WORD_EBX: code = CODE_EBX;
      WORD_ECX: code = CODE_ECX;
      WORD_EDX: code = CODE_EDX;
      default:  code = 8'h00;
    endcase
    return code;
  endfunction

  // Snapshot layout is {eax, ebx, ecx, edx}, eax in the top word.
  function automatic logic [31:0] snap_word(input logic [127:0] snap, input logic [1:0] word);
    logic [31:0] w;
    case (word)
      WORD_EAX: w = snap[127:96];
      WORD_EBX: w = snap[95:64];
      WORD_ECX: w = snap[63:32];
      WORD_EDX: w = snap[31:0];
      default:  w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ctx_ram.sv
// Single-port synchronous frame RAM, DEPTH*4 words of 32 bits, registered read.
module ctx_ram #(
  parameter int DEPTH = 64
) (
  input  logic                         clock,
  input  logic                         we,
  input  logic [$clog2(DEPTH*4)-1:0]   addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem_r [DEPTH*4];
  logic [31:0] rdata_r;

  // Write port and registered read port share one address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/call_context_ctrl.sv
// Saves the four-register context on CALL and replays it through the
// write-back port on RET. Optional sticky error flags: CTX_ERR_FLAG_EN.
module call_context_ctrl
  import ctx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     call_flag,
  input  logic                     ret_flag,
  input  logic [31:0]              r_eax,
  input  logic [31:0]              r_ebx,
  input  logic [31:0]              r_ecx,
  input  logic [31:0]              r_edx,
  output logic                     busy,
  output logic                     wb_flag,
  output logic [7:0]               wb_code,
  output logic [31:0]              wb_data,
  output logic [$clog2(DEPTH):0]   depth
`ifdef CTX_ERR_FLAG_EN
  ,
  output logic                     err_overflow,
  output logic                     err_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] DEPTH_ONE = (AW+1)'(1);

  ctx_state_e     state_r, state_nxt_s;
  logic [2:0]     cnt_r, cnt_nxt_s;
  logic [AW:0]    depth_r, depth_nxt_s;
  logic [127:0]   snap_r, snap_nxt_s;
  logic           busy_r, rd_pend_r, rd_issue_s, ram_we_s;
  logic [7:0]     code_r;
  logic [31:0]    ram_wdata_s, ram_rdata_s;
  logic [AW+1:0]  ram_addr_s;
`ifdef CTX_ERR_FLAG_EN
  logic           ovf_s, unf_s, err_ovf_r, err_unf_r;
`endif

  // Next-state, RAM control and frame-depth bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    depth_nxt_s = depth_r;
    snap_nxt_s  = snap_r;
    ram_we_s    = 1'b0;
    rd_issue_s  = 1'b0;
    ram_addr_s  = {depth_r[AW-1:0], cnt_r[1:0]};
    ram_wdata_s = snap_word(snap_r, cnt_r[1:0]);
`ifdef CTX_ERR_FLAG_EN
    ovf_s       = 1'b0;
    unf_s       = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        // CALL wins over a simultaneous RET; the RET is dropped either way.
        if (call_flag) begin
          if (depth_r != DEPTH_MAX) begin
            snap_nxt_s  = {r_eax, r_ebx, r_ecx, r_edx};
            state_nxt_s = ST_SAVE;
            cnt_nxt_s   = 3'd0;
          end else begin
`ifdef CTX_ERR_FLAG_EN
            ovf_s = 1'b1;
`endif
          end
        end else if (ret_flag) begin
          if (depth_r != {(AW+1){1'b0}}) begin
            depth_nxt_s = depth_r - DEPTH_ONE;
            state_nxt_s = ST_RESTORE;
            cnt_nxt_s   = 3'd0;
          end else begin
`ifdef CTX_ERR_FLAG_EN
            unf_s = 1'b1;
`endif
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SAVE: begin
        ram_we_s = 1'b1;
        if (cnt_r == 3'd3) begin
          depth_nxt_s = depth_r + DEPTH_ONE;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      ST_RESTORE: begin
        // Reads occupy cycles 0..3; cycle 4 only drains the last RAM read.
        if (cnt_r == 3'd4) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 3'd0;
        end else begin
          rd_issue_s = 1'b1;
          cnt_nxt_s  = cnt_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // State, depth, snapshot and write-back pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      depth_r   <= {(AW+1){1'b0}};
      snap_r    <= {128{1'b0}};
      busy_r    <= 1'b0;
      rd_pend_r <= 1'b0;
      code_r    <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      depth_r   <= depth_nxt_s;
      snap_r    <= snap_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      rd_pend_r <= rd_issue_s;
      code_r    <= rd_issue_s ? reg_code(cnt_r[1:0]) : 8'h00;
    end
  end

`ifdef CTX_ERR_FLAG_EN
  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      err_ovf_r <= err_ovf_r | ovf_s;
      err_unf_r <= err_unf_r | unf_s;
    end
  end

  assign err_overflow  = err_ovf_r;
  assign err_underflow = err_unf_r;
`endif

  ctx_ram #(.DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign busy    = busy_r;
  assign depth   = depth_r;
  assign wb_flag = rd_pend_r;
  assign wb_code = code_r;
  // RAM output is already registered; gate it so idle cycles show zero.
  assign wb_data = rd_pend_r ? ram_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_call_context_ctrl.sv
// Randomized scoreboard bench for call_context_ctrl (DEPTH=4) against a
// frame-stack reference model; error-flag checks follow CTX_ERR_FLAG_EN.
module tb_call_context_ctrl;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        call_flag = 1'b0, ret_flag = 1'b0;
  logic [31:0] r_eax = 32'h0, r_ebx = 32'h0, r_ecx = 32'h0, r_edx = 32'h0;
  logic        busy, wb_flag;
  logic [7:0]  wb_code;
  logic [31:0] wb_data;
  logic [2:0]  depth;
`ifdef CTX_ERR_FLAG_EN
  logic        err_overflow, err_underflow;
`endif

  call_context_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .call_flag(call_flag), .ret_flag(ret_flag),
    .r_eax(r_eax), .r_ebx(r_ebx), .r_ecx(r_ecx), .r_edx(r_edx),
    .busy(busy), .wb_flag(wb_flag), .wb_code(wb_code), .wb_data(wb_data),
    .depth(depth)
`ifdef CTX_ERR_FLAG_EN
    , .err_overflow(err_overflow), .err_underflow(err_underflow)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a stack of saved frames plus sticky error flags.
  logic [127:0] stack[$];
  logic [39:0]  exp_q[$];
  bit           m_ovf = 1'b0, m_unf = 1'b0;
  logic [39:0]  mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic push_frame_wb(input logic [127:0] fr);
    exp_q.push_back({8'h80, fr[127:96]});
    exp_q.push_back({8'hA0, fr[95:64]});
    exp_q.push_back({8'hC0, fr[63:32]});
    exp_q.push_back({8'hE0, fr[31:0]});
  endtask

  task automatic check_flags();
`ifdef CTX_ERR_FLAG_EN
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_unf));
`endif
  endtask

  // One CALL/RET request; expected busy length, depth and write-backs come from the model.
  task automatic op(input bit c, input bit r, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] x, input logic [31:0] d);
    int exp_busy;
    int n;
    logic [127:0] fr;
    exp_busy = 0;
    if (c) begin
      if (stack.size() < DEPTH) begin
        stack.push_back({a, b, x, d});
        exp_busy = 4;
      end else m_ovf = 1'b1;
    end else if (r) begin
      if (stack.size() > 0) begin
        fr = stack.pop_back();
        push_frame_wb(fr);
        exp_busy = 5;
      end else m_unf = 1'b1;
    end
    @(posedge clock); #1;
    call_flag = c; ret_flag = r;
    r_eax = a; r_ebx = b; r_ecx = x; r_edx = d;
    @(posedge clock); #1;
    call_flag = 1'b0; ret_flag = 1'b0;
    r_eax = $urandom; r_ebx = $urandom; r_ecx = $urandom; r_edx = $urandom;
    n = 0;
    // Requests raised while busy must be ignored.
    while (busy === 1'b1 && n < 20) begin
      n++;
      call_flag = 1'($urandom_range(0, 1));
      ret_flag  = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    call_flag = 1'b0; ret_flag = 1'b0;
    chk("busy_cycles", 32'(n), 32'(exp_busy));
    chk("depth", 32'(depth), 32'(stack.size()));
    check_flags();
  endtask

  // Scoreboard monitor: every write-back pulse must match the next expected entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (wb_flag === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", {24'h0, wb_code}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_code", {24'h0, wb_code}, {24'h0, mon_e[39:32]});
          chk("wb_data", wb_data, mon_e[31:0]);
        end
      end else begin
        chk("idle_wb_code", {24'h0, wb_code}, 32'h0);
        chk("idle_wb_data", wb_data, 32'h0);
      end
    end
  end

  initial begin
    bit c, r;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_depth", 32'(depth), 32'h0);
    chk("reset_wb_flag", 32'(wb_flag), 32'h0);
    check_flags();
    reset = 1'b0;

    // Basic save then restore with fixed values.
    op(1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    op(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
    // Underflow.
    op(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
    // Fill to DEPTH and overflow once.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);

    // Random mix of CALL, RET and both together.
    for (int i = 0; i < 40; i++) begin
      c = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      op(c, r, $urandom, $urandom, $urandom, $urandom);
    end

    // Drain, then CALL and RET together at depth 1.
    while (stack.size() > 0) op(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
    op(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
    op(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
    chk("both_depth2", 32'(depth), 32'h2);

    // Reset in the middle of a restore.
    begin
      logic [127:0] fr;
      fr = stack.pop_back();
      push_frame_wb(fr);
      @(posedge clock); #1; ret_flag = 1'b1;
      @(posedge clock); #1; ret_flag = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("restore_c2_wb_flag", 32'(wb_flag), 32'h1);
      reset = 1'b1;
      #1;
      chk("abort_wb_flag", 32'(wb_flag), 32'h0);
      chk("abort_wb_data", wb_data, 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_depth", 32'(depth), 32'h0);
      exp_q.delete();
      stack.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      check_flags();
      @(posedge clock); #1;
      reset = 1'b0;
    end
    op(1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    op(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);

    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
